// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Parametrised inter-stage pipeline register for the 5-stage core. Carries a
// bundle of {PC, ALU result, store data, destination register, control} from
// one stage to the next behind a valid/ready handshake.
//
// SKID_EN = 1 : two-entry register (main + skid). in_ready is a flop output,
//               so no combinational path runs from out_ready to in_ready.
// SKID_EN = 0 : single main register, in_ready = !out_valid | out_ready.
//
// Outputs are always driven from the main register only (no in_* -> out_*
// path). A flush empties the stage and zeroes the held control fields so
// that a stale bundle can never look like a live one downstream.
// stall_count counts cycles where out_valid=1 and out_ready=0 and saturates.
//
// Ports
//   clk          clock, all state on the rising edge
//   reset_n      asynchronous active-low reset
//   in_valid     upstream offers a bundle
//   in_ready     stage accepts a bundle this cycle
//   in_pc/in_alu/in_data2/in_rd/in_ctrl   incoming bundle fields
//   flush        synchronous kill of every held bundle
//   out_valid    output bundle valid
//   out_ready    downstream accepts the output bundle
//   out_pc/out_alu/out_data2/out_rd/out_ctrl   held bundle fields
//   stall_count  saturating count of back-pressured cycles
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int DATA_W  = 32,
  parameter int RD_W    = 5,
  parameter int CTRL_W  = 6,
  parameter int SKID_EN = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_data2,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [CTRL_W-1:0] in_ctrl,

  input  logic              flush,

  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_alu,
  output logic [DATA_W-1:0] out_data2,
  output logic [RD_W-1:0]   out_rd,
  output logic [CTRL_W-1:0] out_ctrl,

  output logic [CNT_W-1:0]  stall_count
);

  localparam bit SKID = (SKID_EN != 0);

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] data2;
    logic [RD_W-1:0]   rd;
    logic [CTRL_W-1:0] ctrl;
  } bundle_t;

  // State encodes occupancy: EMPTY = 0 bundles, ONE = main only,
  // FULL = main + skid. FULL is unreachable when SKID_EN = 0.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_nxt;
  bundle_t         main_q;
  bundle_t         skid_q;
  bundle_t         in_b;
  logic            in_ready_q;
  logic [CNT_W-1:0] stall_q;

  logic in_fire;
  logic out_fire;
  logic ld_main_in;
  logic ld_main_skid;
  logic ld_skid;

  assign in_b = '{pc: in_pc, alu: in_alu, data2: in_data2, rd: in_rd, ctrl: in_ctrl};

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  assign out_valid = (state_q != EMPTY);

  generate
    if (SKID) begin : g_skid_ready
      assign in_ready = in_ready_q;
    end else begin : g_comb_ready
      assign in_ready = !out_valid || out_ready;
    end
  endgenerate

  assign in_fire  = in_valid  && in_ready;
  assign out_fire = out_valid && out_ready;

  // ---------------------------------------------------------------------------
  // Next-state and load decisions
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case/if tree can leave a value unassigned (which would
    // infer a latch).
    state_nxt    = state_q;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;

    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          ld_main_in = 1'b1;
          state_nxt  = ONE;
        end
      end

      ONE: begin
        if (in_fire && out_fire) begin
          // Downstream takes main while upstream refills it.
          ld_main_in = 1'b1;
        end else if (in_fire && SKID) begin
          // Main is stalled; park the new bundle behind it.
          ld_skid   = 1'b1;
          state_nxt = FULL;
        end else if (out_fire) begin
          state_nxt = EMPTY;
        end
      end

      FULL: begin
        if (out_fire) begin
          ld_main_skid = 1'b1;
          state_nxt    = ONE;
        end
      end

      default: begin
        state_nxt = EMPTY;
      end
    endcase

    // Flush wins over everything: the stage empties and any bundle accepted
    // this cycle is dropped (upstream still sees it as transferred).
    if (flush) begin
      state_nxt    = EMPTY;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State, holding registers and registered in_ready
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: the data registers are reset along with the control state; the
    // held fields are visible on the outputs and must read as zero after
    // reset, so they are not left as unreset storage.
    if (!reset_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here
      // samples the pre-edge values regardless of statement order.
      state_q    <= state_nxt;
      // in_ready for the next cycle is known now: the stage can accept
      // unless it will be holding two bundles.
      in_ready_q <= (state_nxt != FULL);

      if (flush) begin
        // Only the control fields are cleared; data/rd keep their values.
        main_q.ctrl <= '0;
        skid_q.ctrl <= '0;
      end else begin
        if (ld_main_in) begin
          main_q <= in_b;
        end else if (ld_main_skid) begin
          main_q <= skid_q;
        end

        if (ld_skid) begin
          skid_q <= in_b;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating back-pressure counter (cleared only by reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign out_pc      = main_q.pc;
  assign out_alu     = main_q.alu;
  assign out_data2   = main_q.data2;
  assign out_rd      = main_q.rd;
  assign out_ctrl    = main_q.ctrl;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Three instances share one set of inputs:
//   dut    default parameters (skid buffer, 16-bit counter)
//   dut_s  CNT_W = 4, for counter saturation
//   dut_n  SKID_EN = 0, combinational in_ready
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// The reference model is a bundle queue with a capacity rule per variant.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] data2;
    logic [4:0]  rd;
    logic [5:0]  ctrl;
  } bundle_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_pc = '0, in_alu = '0, in_data2 = '0;
  logic [4:0]  in_rd = '0;
  logic [5:0]  in_ctrl = '0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;

  logic        d_in_ready, d_out_valid;
  logic [31:0] d_out_pc, d_out_alu, d_out_data2;
  logic [4:0]  d_out_rd;
  logic [5:0]  d_out_ctrl;
  logic [15:0] d_stall;

  logic        s_in_ready, s_out_valid;
  logic [31:0] s_out_pc, s_out_alu, s_out_data2;
  logic [4:0]  s_out_rd;
  logic [5:0]  s_out_ctrl;
  logic [3:0]  s_stall;

  logic        n_in_ready, n_out_valid;
  logic [31:0] n_out_pc, n_out_alu, n_out_data2;
  logic [4:0]  n_out_rd;
  logic [5:0]  n_out_ctrl;
  logic [15:0] n_stall;

  bundle_t d_out_b, n_out_b;
  assign d_out_b = {d_out_pc, d_out_alu, d_out_data2, d_out_rd, d_out_ctrl};
  assign n_out_b = {n_out_pc, n_out_alu, n_out_data2, n_out_rd, n_out_ctrl};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(d_in_ready),
    .in_pc(in_pc), .in_alu(in_alu), .in_data2(in_data2), .in_rd(in_rd), .in_ctrl(in_ctrl),
    .flush(flush),
    .out_valid(d_out_valid), .out_ready(out_ready),
    .out_pc(d_out_pc), .out_alu(d_out_alu), .out_data2(d_out_data2),
    .out_rd(d_out_rd), .out_ctrl(d_out_ctrl),
    .stall_count(d_stall)
  );

  pipe_stage_reg #(.CNT_W(4)) dut_s (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .in_pc(in_pc), .in_alu(in_alu), .in_data2(in_data2), .in_rd(in_rd), .in_ctrl(in_ctrl),
    .flush(flush),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_pc(s_out_pc), .out_alu(s_out_alu), .out_data2(s_out_data2),
    .out_rd(s_out_rd), .out_ctrl(s_out_ctrl),
    .stall_count(s_stall)
  );

  pipe_stage_reg #(.SKID_EN(0)) dut_n (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(n_in_ready),
    .in_pc(in_pc), .in_alu(in_alu), .in_data2(in_data2), .in_rd(in_rd), .in_ctrl(in_ctrl),
    .flush(flush),
    .out_valid(n_out_valid), .out_ready(out_ready),
    .out_pc(n_out_pc), .out_alu(n_out_alu), .out_data2(n_out_data2),
    .out_rd(n_out_rd), .out_ctrl(n_out_ctrl),
    .stall_count(n_stall)
  );

  function automatic bundle_t rand_bundle();
    bundle_t b;
    b.pc    = $urandom;
    b.alu   = $urandom;
    b.data2 = $urandom;
    b.rd    = 5'($urandom);
    b.ctrl  = 6'($urandom);
    return b;
  endfunction

  function automatic bundle_t mk_bundle(input logic [31:0] pc, input logic [5:0] ctrl);
    bundle_t b;
    b      = rand_bundle();
    b.pc   = pc;
    b.ctrl = ctrl;
    return b;
  endfunction

  task automatic drive(input logic v, input bundle_t b);
    in_valid = v;
    in_pc    = b.pc;
    in_alu   = b.alu;
    in_data2 = b.data2;
    in_rd    = b.rd;
    in_ctrl  = b.ctrl;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n   = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, '0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Reset asserted asynchronously while the stage is full and stalled.
  task automatic test_reset();
    bundle_t a, b;
    do_reset();
    a = mk_bundle(32'h100, 6'h3f);
    b = mk_bundle(32'h104, 6'h3f);
    @(negedge clk); drive(1'b1, a);
    @(negedge clk); drive(1'b1, b);
    @(negedge clk); drive(1'b0, '0);
    @(negedge clk); #1;
    checks++;
    if (d_out_valid !== 1'b1 || d_out_b !== a) begin
      errors++; $display("FAIL reset_pre got v=%b pc=%h exp v=1 pc=%h", d_out_valid, d_out_pc, a.pc);
    end
    checks++;
    if (d_stall !== 16'd2) begin
      errors++; $display("FAIL reset_pre_stall got %0d exp 2", d_stall);
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (d_out_valid !== 1'b0 || d_stall !== 16'd0) begin
      errors++; $display("FAIL reset_async got v=%b stall=%0d exp v=0 stall=0", d_out_valid, d_stall);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++;
    if (d_in_ready !== 1'b1 || d_out_valid !== 1'b0 || d_out_ctrl !== 6'h0 ||
        d_out_pc !== 32'h0 || d_stall !== 16'd0) begin
      errors++;
      $display("FAIL reset_release got rdy=%b v=%b ctrl=%h pc=%h stall=%0d exp 1 0 00 0 0",
               d_in_ready, d_out_valid, d_out_ctrl, d_out_pc, d_stall);
    end
    @(negedge clk); #1;
    checks++;
    if (d_in_ready !== 1'b1 || d_out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_idle got rdy=%b v=%b exp 1 0", d_in_ready, d_out_valid);
    end
  endtask

  // Consecutive bundles with no back-pressure: 1-cycle latency.
  task automatic test_stream();
    bundle_t bs [3];
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) bs[i] = mk_bundle(32'(4 * i), 6'($urandom));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i < 3) drive(1'b1, bs[i]); else drive(1'b0, '0);
      #1;
      checks++;
      if (d_in_ready !== 1'b1) begin
        errors++; $display("FAIL stream_ready[%0d] got %b exp 1", i, d_in_ready);
      end
      checks++;
      if (i == 0) begin
        if (d_out_valid !== 1'b0) begin
          errors++; $display("FAIL stream_first_valid got %b exp 0", d_out_valid);
        end
      end else if (d_out_valid !== 1'b1 || d_out_b !== bs[i-1]) begin
        errors++; $display("FAIL stream_out[%0d] got v=%b %h exp v=1 %h", i, d_out_valid, d_out_b, bs[i-1]);
      end
    end
    @(negedge clk); #1;
    checks++;
    if (d_out_valid !== 1'b0) begin
      errors++; $display("FAIL stream_drain got %b exp 0", d_out_valid);
    end
  endtask

  // Two bundles into a stalled stage fill the skid; release drains in order.
  task automatic test_back_pressure();
    bundle_t a, b;
    logic [15:0] exp_stall [7] = '{16'd0, 16'd0, 16'd1, 16'd2, 16'd3, 16'd3, 16'd3};
    logic        exp_rdy   [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic        exp_v     [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    a = mk_bundle(32'h10, 6'h15);
    b = mk_bundle(32'h14, 6'h2a);
    do_reset();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      drive(i == 0 ? 1'b1 : (i == 1), i == 0 ? a : b);
      out_ready = (i >= 4);
      #1;
      checks++;
      if (d_in_ready !== exp_rdy[i] || d_out_valid !== exp_v[i] || d_stall !== exp_stall[i]) begin
        errors++;
        $display("FAIL bp_ctl[%0d] got rdy=%b v=%b stall=%0d exp rdy=%b v=%b stall=%0d",
                 i, d_in_ready, d_out_valid, d_stall, exp_rdy[i], exp_v[i], exp_stall[i]);
      end
      if (i >= 1 && i <= 5) begin
        checks++;
        if (d_out_b !== ((i <= 4) ? a : b)) begin
          errors++; $display("FAIL bp_data[%0d] got %h exp %h", i, d_out_b, (i <= 4) ? a : b);
        end
      end
    end
  endtask

  // Flush from FULL and from ONE (with an accepted bundle in the same cycle).
  task automatic test_flush();
    bundle_t a, b, k, c, e;
    a = mk_bundle(32'h30, 6'h3f);
    b = mk_bundle(32'h34, 6'h3f);
    k = mk_bundle(32'h20, 6'h3f);
    c = mk_bundle(32'h40, 6'h15);
    e = mk_bundle(32'h24, 6'h3f);
    do_reset();
    @(negedge clk); drive(1'b1, a);
    @(negedge clk); drive(1'b1, b);
    @(negedge clk); drive(1'b1, k); flush = 1'b1;
    #1;
    checks++;
    if (d_in_ready !== 1'b0) begin
      errors++; $display("FAIL flush_full_rdy got %b exp 0", d_in_ready);
    end
    @(negedge clk); drive(1'b0, '0); flush = 1'b0; out_ready = 1'b1;
    #1;
    checks++;
    if (d_out_valid !== 1'b0 || d_out_ctrl !== 6'h0 || d_in_ready !== 1'b1 || d_out_pc !== 32'h30) begin
      errors++;
      $display("FAIL flush_full got v=%b ctrl=%h rdy=%b pc=%h exp 0 00 1 00000030",
               d_out_valid, d_out_ctrl, d_in_ready, d_out_pc);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++;
      if (d_out_valid !== 1'b0) begin
        errors++; $display("FAIL flush_full_leak[%0d] got v=%b pc=%h exp v=0", i, d_out_valid, d_out_pc);
      end
    end
    @(negedge clk); drive(1'b1, c); out_ready = 1'b0;
    @(negedge clk); drive(1'b1, e); flush = 1'b1;
    #1;
    checks++;
    if (d_in_ready !== 1'b1 || d_out_valid !== 1'b1 || d_out_b !== c) begin
      errors++; $display("FAIL flush_one_pre got rdy=%b v=%b %h exp 1 1 %h", d_in_ready, d_out_valid, d_out_b, c);
    end
    @(negedge clk); drive(1'b0, '0); flush = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (d_out_valid !== 1'b0 || d_out_ctrl !== 6'h0) begin
        errors++; $display("FAIL flush_one[%0d] got v=%b ctrl=%h exp 0 00", i, d_out_valid, d_out_ctrl);
      end
      @(negedge clk);
    end
    checks++;
    if (d_stall !== 16'd3) begin
      errors++; $display("FAIL flush_stall got %0d exp 3", d_stall);
    end
  endtask

  // 4-bit counter held under back-pressure must stop at 15; flush keeps it.
  task automatic test_saturation();
    do_reset();
    @(negedge clk); drive(1'b1, rand_bundle());
    for (int k = 0; k < 22; k++) begin
      @(negedge clk); drive(1'b0, '0);
      #1;
      checks++;
      if (s_stall !== 4'((k > 15) ? 15 : k) || s_out_valid !== 1'b1) begin
        errors++; $display("FAIL sat[%0d] got %0d v=%b exp %0d v=1", k, s_stall, s_out_valid, (k > 15) ? 15 : k);
      end
    end
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    #1;
    checks++;
    if (s_stall !== 4'd15 || s_out_valid !== 1'b0) begin
      errors++; $display("FAIL sat_flush got %0d v=%b exp 15 v=0", s_stall, s_out_valid);
    end
  endtask

  // Random traffic on the skid variant against a capacity-2 queue model.
  task automatic test_skid_random();
    bundle_t     q[$];
    bundle_t     b;
    logic [15:0] exp_stall;
    logic        v, ordy, fl, exp_rdy, ifire, ofire;
    do_reset();
    exp_stall = '0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      v    = ($urandom_range(0, 99) < 70);
      ordy = ($urandom_range(0, 99) < 55);
      fl   = ($urandom_range(0, 99) < 3);
      b    = rand_bundle();
      drive(v, b); out_ready = ordy; flush = fl;
      #1;
      exp_rdy = (q.size() < 2);
      checks++;
      if (d_in_ready !== exp_rdy || d_out_valid !== (q.size() > 0)) begin
        errors++;
        $display("FAIL skid_ctl[%0d] got rdy=%b v=%b exp rdy=%b v=%b", i, d_in_ready, d_out_valid, exp_rdy, q.size() > 0);
      end
      if (q.size() > 0) begin
        checks++;
        if (d_out_b !== q[0]) begin
          errors++; $display("FAIL skid_data[%0d] got %h exp %h", i, d_out_b, q[0]);
        end
      end
      checks++;
      if (d_stall !== exp_stall) begin
        errors++; $display("FAIL skid_stall[%0d] got %0d exp %0d", i, d_stall, exp_stall);
      end
      ifire = v && exp_rdy;
      ofire = (q.size() > 0) && ordy;
      if ((q.size() > 0) && !ordy && exp_stall != 16'hffff) exp_stall++;
      if (fl) q.delete();
      else begin
        if (ofire) void'(q.pop_front());
        if (ifire) q.push_back(b);
      end
    end
    @(negedge clk); drive(1'b0, '0); flush = 1'b0;
  endtask

  // Non-skid variant: continuous in_valid, random out_ready, 100 bundles.
  task automatic test_noskid_random();
    bundle_t q[$];
    bundle_t b;
    int      accepted, emitted;
    logic    ordy, exp_rdy;
    do_reset();
    accepted = 0;
    emitted  = 0;
    for (int i = 0; i < 2000 && accepted < 100; i++) begin
      @(negedge clk);
      ordy = $urandom_range(0, 1);
      b    = rand_bundle();
      drive(1'b1, b); out_ready = ordy;
      #1;
      exp_rdy = (q.size() == 0) || ordy;
      checks++;
      if (n_in_ready !== exp_rdy || n_out_valid !== (q.size() > 0)) begin
        errors++;
        $display("FAIL noskid_ctl[%0d] got rdy=%b v=%b exp rdy=%b v=%b", i, n_in_ready, n_out_valid, exp_rdy, q.size() > 0);
      end
      if (q.size() > 0) begin
        checks++;
        if (n_out_b !== q[0]) begin
          errors++; $display("FAIL noskid_data[%0d] got %h exp %h", i, n_out_b, q[0]);
        end
        if (ordy) begin
          void'(q.pop_front());
          emitted++;
        end
      end
      if (exp_rdy) begin
        q.push_back(b);
        accepted++;
      end
    end
    @(negedge clk); drive(1'b0, '0); out_ready = 1'b1;
    for (int i = 0; i < 4 && q.size() > 0; i++) begin
      #1;
      checks++;
      if (n_out_valid !== 1'b1 || n_out_b !== q[0]) begin
        errors++; $display("FAIL noskid_drain[%0d] got v=%b %h exp v=1 %h", i, n_out_valid, n_out_b, q[0]);
      end
      void'(q.pop_front());
      emitted++;
      @(negedge clk);
    end
    #1;
    checks++;
    if (accepted != 100 || emitted != 100 || n_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL noskid_count got acc=%0d emit=%0d v=%b exp 100 100 0", accepted, emitted, n_out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_back_pressure();
    test_flush();
    test_saturation();
    test_skid_random();
    test_noskid_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
